// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the UART-fed data-memory loader.
// Optional checksum trailer is enabled by defining MEM_LOADER_CHECKSUM_EN.
package mem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);
    localparam int WORD_W         = 8 * BYTES_PER_WORD;
    localparam int COUNT_W        = 14;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WRITE = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_e;

    // Byte address of word k relative to a word-aligned base; wraps mod 2^32.
    function automatic logic [31:0] word_addr(input logic [29:0]        base_word,
                                              input logic [COUNT_W-1:0] k);
        return {base_word, 2'b00} + {16'b0, k, 2'b00};
    endfunction

endpackage

// File: rtl/mem_loader_byte_packer.sv
// Little-endian byte-to-word packer: shift register, byte index and a
// word-complete flag that fires on the cycle the last byte of a word is taken.
module byte_packer
    import mem_loader_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear_i,
    input  logic              accept_i,
    input  logic [7:0]        byte_i,
    output logic [WORD_W-1:0] word_o,
    output logic              last_o
);

    localparam int SHIFT_W = WORD_W - 8;
    localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(BYTES_PER_WORD - 1);

    logic [SHIFT_W-1:0]    shift_q, shift_d;
    logic [BYTE_IDX_W-1:0] idx_q, idx_d;

    // word_o is only meaningful while last_o is high: it is the full word
    // formed by the byte being accepted plus the ones already shifted in.
    assign last_o = accept_i && (idx_q == LAST_IDX);
    assign word_o = {byte_i, shift_q};

    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        if (clear_i) begin
            shift_d = '0;
            idx_d   = '0;
        end else if (accept_i) begin
            idx_d   = idx_q + BYTE_IDX_W'(1);
            shift_d = last_o ? '0 : {byte_i, shift_q[SHIFT_W-1:8]};
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: rtl/mem_loader.sv
// Loads wordCount 32-bit words from a byte stream into data memory.
// Define MEM_LOADER_CHECKSUM_EN to require a 4-byte sum trailer after the data.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [31:0]        baseAddr,
    input  logic [COUNT_W-1:0] wordCount,
    input  logic [7:0]         rxData,
    input  logic               rxValid,
    output logic               rxReady,
    output logic               memWrite,
    output logic [31:0]        address,
    output logic [31:0]        writeData,
    output logic               busy,
    output logic               done,
    output logic               errTimeout,
    output logic               chkErr,
    output logic [COUNT_W-1:0] wordsLoaded,
    output state_e             dbg_state_o
);

    localparam logic [31:0] TMO_LAST = TIMEOUT - 1;

    state_e             state_q, state_d;
    logic [29:0]        base_q, base_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [COUNT_W-1:0] words_q, words_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        tmo_q, tmo_d;
    logic               err_tmo_q, err_tmo_d;

    logic               accept;
    logic               tmo_hit;
    logic [WORD_W-1:0]  word_next;
    logic               word_last;
    logic               unused_base_lsbs;

    assign unused_base_lsbs = ^baseAddr[1:0];

    // Handshake: a byte moves only on a rising edge where rxValid and rxReady
    // are both 1; rxReady depends on state alone, never on rxValid.
    assign rxReady     = (state_q == LOAD) || (state_q == CHECK);
    assign accept      = rxValid && rxReady;
    assign memWrite    = (state_q == WRITE);
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign address     = addr_q;
    assign writeData   = wdata_q;
    assign errTimeout  = err_tmo_q;
    assign wordsLoaded = words_q;
    assign dbg_state_o = state_q;

    byte_packer u_packer (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear_i  (state_q == IDLE),
        .accept_i (accept),
        .byte_i   (rxData),
        .word_o   (word_next),
        .last_o   (word_last)
    );

    // The counter only runs while waiting for bytes; WRITE and IDLE zero it,
    // so every entry to LOAD or CHECK starts a fresh window.
    assign tmo_hit = (TIMEOUT != 0) && rxReady && !accept && (tmo_q == TMO_LAST);
    assign tmo_d   = (!rxReady || accept) ? 32'd0 : tmo_q + 32'd1;

`ifdef MEM_LOADER_CHECKSUM_EN
    logic [31:0] sum_q, sum_d;
    logic        chk_q, chk_d;
    assign chkErr = chk_q;
`else
    assign chkErr = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        count_d   = count_q;
        words_d   = words_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_tmo_d = err_tmo_q;
`ifdef MEM_LOADER_CHECKSUM_EN
        sum_d     = sum_q;
        chk_d     = chk_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d    = baseAddr[31:2];
                    count_d   = wordCount;
                    words_d   = '0;
                    err_tmo_d = 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
                    sum_d     = '0;
                    chk_d     = 1'b0;
`endif
                    state_d   = (wordCount == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (tmo_hit) begin
                    err_tmo_d = 1'b1;
                    state_d   = IDLE;
                end else if (word_last) begin
                    addr_d  = word_addr(base_q, words_q);
                    wdata_d = word_next;
`ifdef MEM_LOADER_CHECKSUM_EN
                    sum_d   = sum_q + word_next;
`endif
                    state_d = WRITE;
                end
            end
            WRITE: begin
                words_d = words_q + COUNT_W'(1);
                if (words_d != count_q) begin
                    state_d = LOAD;
                end else begin
`ifdef MEM_LOADER_CHECKSUM_EN
                    state_d = CHECK;
`else
                    state_d = DONE;
`endif
                end
            end
            CHECK: begin
`ifdef MEM_LOADER_CHECKSUM_EN
                if (tmo_hit) begin
                    err_tmo_d = 1'b1;
                    state_d   = IDLE;
                end else if (word_last) begin
                    chk_d   = (word_next != sum_q);
                    state_d = DONE;
                end
`else
                state_d = IDLE;
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            base_q    <= '0;
            count_q   <= '0;
            words_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            tmo_q     <= '0;
            err_tmo_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            count_q   <= count_d;
            words_q   <= words_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            tmo_q     <= tmo_d;
            err_tmo_q <= err_tmo_d;
        end
    end

`ifdef MEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sum_q <= '0;
            chk_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            chk_q <= chk_d;
        end
    end
`endif

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: byte-stream driver, write scoreboard
// and directed plus randomized loads.
module tb_mem_loader;
    import mem_loader_pkg::*;

    localparam int unsigned TMO = 16;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] baseAddr;
    logic [13:0] wordCount;
    logic [7:0]  rxData;
    logic        rxValid;
    logic        rxReady;
    logic        memWrite;
    logic [31:0] address;
    logic [31:0] writeData;
    logic        busy;
    logic        done;
    logic        errTimeout;
    logic        chkErr;
    logic [13:0] wordsLoaded;
    state_e      dbg_state;

    always #5 clock = ~clock;

    mem_loader #(.TIMEOUT(TMO)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .baseAddr    (baseAddr),
        .wordCount   (wordCount),
        .rxData      (rxData),
        .rxValid     (rxValid),
        .rxReady     (rxReady),
        .memWrite    (memWrite),
        .address     (address),
        .writeData   (writeData),
        .busy        (busy),
        .done        (done),
        .errTimeout  (errTimeout),
        .chkErr      (chkErr),
        .wordsLoaded (wordsLoaded),
        .dbg_state_o (dbg_state)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          done_cnt = 0;
    logic [63:0] exp_q[$];          // {address, data} of every write still owed
    logic [31:0] last_a = '0;
    logic [31:0] last_d = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- scoreboard / per-cycle compare ----------------
    initial begin : compare
        logic        rst_edge;
        logic        prev_mw;
        logic        prev_done;
        logic [63:0] e;
        prev_mw   = 1'b0;
        prev_done = 1'b0;
        forever begin
            @(posedge clock);
            rst_edge = !reset_n;
            @(negedge clock);
            if (rst_edge) begin
                last_a    = '0;
                last_d    = '0;
                prev_mw   = 1'b0;
                prev_done = 1'b0;
            end else begin
                if (memWrite) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL spurious_write: got %h@%h expected no write", writeData, address);
                    end else begin
                        e = exp_q.pop_front();
                        check("write", {address, writeData}, e);
                        last_a = e[63:32];
                        last_d = e[31:0];
                    end
                    check("ready_low_in_write", rxReady, 0);
                    check("write_one_cycle", prev_mw, 0);
                end else begin
                    check("addr_hold", address, last_a);
                    check("data_hold", writeData, last_d);
                end
                if (done) begin
                    done_cnt++;
                    check("done_one_cycle_cmp", prev_done, 0);
                end
                prev_mw   = memWrite;
                prev_done = done;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        rxValid = 1'b0;
        rxData  = 8'($urandom);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_start(input logic [31:0] base, input logic [13:0] wc);
        rxValid   = 1'b0;
        baseAddr  = base;
        wordCount = wc;
        start     = 1'b1;
        @(posedge clock);
        #1;
        start     = 1'b0;
        baseAddr  = $urandom;
        wordCount = 14'($urandom);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit r;
        int cyc;
        rxData  = b;
        rxValid = 1'b1;
        cyc     = 0;
        do begin
            @(negedge clock);
            r = rxReady;
            @(posedge clock);
            #1;
            cyc++;
        end while (!r && cyc < 100);
        if (!r) begin
            n_checks++;
            $display("FAIL byte_accept: byte %h got no rxReady in 100 cycles, required acceptance", b);
        end
    endtask

    task automatic finish_load(input int d0, input logic [13:0] wc, input bit exp_chk);
        bit seen;
        seen    = 1'b0;
        rxValid = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clock);
            seen = done;
        end
        check("done_seen", seen, 1);
        if (seen) begin
            check("words_loaded", wordsLoaded, wc);
            check("chk_err", chkErr, exp_chk);
            check("busy_in_done", busy, 1);
            check("no_timeout", errTimeout, 0);
        end
        @(negedge clock);
        check("busy_after_done", busy, 0);
        check("done_cleared", done, 0);
        @(posedge clock);
        #1;
        check("done_count", done_cnt - d0, 1);
        check("writes_drained", exp_q.size(), 0);
    endtask

    task automatic run_load(input logic [31:0] base, input int wc, input bit cont,
                            input bit poke, input bit bad_sum);
        logic [31:0] w;
        logic [31:0] sum;
        logic [31:0] a;
        bit          exp_chk;
        int          d0;
        d0      = done_cnt;
        sum     = '0;
        exp_chk = 1'b0;
        do_start(base, 14'(wc));
        for (int k = 0; k < wc; k++) begin
            w   = $urandom;
            sum = sum + w;
            a   = (base & 32'hFFFF_FFFC) + 32'(4 * k);
            for (int b = 0; b < 4; b++) begin
                if (!cont) idle($urandom_range(0, 2));
                if (poke && !cont && k == 0 && b == 1) begin
                    rxValid   = 1'b0;
                    start     = 1'b1;
                    baseAddr  = $urandom;
                    wordCount = 14'($urandom);
                    @(posedge clock);
                    #1;
                    start     = 1'b0;
                end
                send_byte(w[8*b +: 8]);
            end
            exp_q.push_back({a, w});
        end
`ifdef MEM_LOADER_CHECKSUM_EN
        if (bad_sum) begin
            sum     = sum ^ (32'h1 << $urandom_range(0, 31));
            exp_chk = 1'b1;
        end
        for (int b = 0; b < 4; b++) begin
            if (!cont) idle($urandom_range(0, 2));
            send_byte(sum[8*b +: 8]);
        end
`else
        if (bad_sum) idle(1);
`endif
        finish_load(d0, 14'(wc), exp_chk);
    endtask

    task automatic load_two(input logic [31:0] base, input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] cs, input bit exp_chk);
        int d0;
        d0 = done_cnt;
        do_start(base, 14'd2);
        for (int i = 0; i < 4; i++) send_byte(w0[8*i +: 8]);
        exp_q.push_back({base & 32'hFFFF_FFFC, w0});
        for (int i = 0; i < 4; i++) send_byte(w1[8*i +: 8]);
        exp_q.push_back({(base & 32'hFFFF_FFFC) + 32'd4, w1});
`ifdef MEM_LOADER_CHECKSUM_EN
        for (int i = 0; i < 4; i++) send_byte(cs[8*i +: 8]);
        finish_load(d0, 14'd2, exp_chk);
`else
        if (cs == 32'hFFFF_FFFF) idle(1);
        finish_load(d0, 14'd2, 1'b0 & exp_chk);
`endif
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int d0;
        reset_n   = 1'b0;
        start     = 1'b0;
        rxValid   = 1'b0;
        rxData    = '0;
        baseAddr  = '0;
        wordCount = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_flags", {rxReady, memWrite, busy, done, errTimeout, chkErr}, 0);
        check("reset_addr", address, 0);
        check("reset_data", writeData, 0);
        check("reset_words", wordsLoaded, 0);
        check("reset_state", dbg_state, IDLE);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        idle(2);

        // Two-word load from 0x100; values pinned by hand.
        load_two(32'h0000_0100, 32'h1234_5678, 32'hDEAD_BEEF, 32'hF0E2_1567, 1'b0);
        check("pin_last_addr", address, 32'h0000_0104);
        check("pin_last_data", writeData, 32'hDEAD_BEEF);
        check("pin_words", wordsLoaded, 14'd2);

        // Zero-word load: done the cycle after start, busy for one cycle.
        d0 = done_cnt;
        do_start(32'h0000_0040, 14'd0);
        @(negedge clock);
        check("zero_done", done, 1);
        check("zero_busy", busy, 1);
        @(negedge clock);
        check("zero_done_gone", done, 0);
        check("zero_busy_gone", busy, 0);
        @(posedge clock);
        #1;
        check("zero_done_count", done_cnt - d0, 1);

        // Timeout after two bytes of a one-word load.
        d0 = done_cnt;
        do_start(32'h0000_0300, 14'd1);
        send_byte(8'hAA);
        send_byte(8'hBB);
        rxValid = 1'b0;
        repeat (TMO - 1) @(posedge clock);
        @(negedge clock);
        check("tmo_still_busy", busy, 1);
        check("tmo_not_yet", errTimeout, 0);
        @(negedge clock);
        check("tmo_flag", errTimeout, 1);
        check("tmo_idle", busy, 0);
        check("tmo_ready_low", rxReady, 0);
        check("tmo_words", wordsLoaded, 0);
        @(posedge clock);
        #1;
        check("tmo_no_done", done_cnt - d0, 0);

        // Reset after the third byte of a word: nothing written, clean restart.
        do_start(32'h0000_0400, 14'd2);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        rxValid = 1'b0;
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(negedge clock);
        check("rst_flags", {rxReady, memWrite, busy, done, errTimeout, chkErr}, 0);
        check("rst_addr", address, 0);
        check("rst_data", writeData, 0);
        check("rst_words", wordsLoaded, 0);
        check("rst_state", dbg_state, IDLE);
        idle(5);
        run_load(32'h0000_0800, 2, 1'b0, 1'b0, 1'b0);

`ifdef MEM_LOADER_CHECKSUM_EN
        load_two(32'h0000_0500, 32'd1, 32'd2, 32'd3, 1'b0);
        load_two(32'h0000_0500, 32'd1, 32'd2, 32'd4, 1'b1);
        check("bad_sum_not_written", writeData, 32'd2);
`endif

        // Back-to-back bytes across four words with the address wrapping.
        run_load(32'hFFFF_FFFC, 4, 1'b1, 1'b0, 1'b0);
        check("wrap_last_addr", address, 32'h0000_0008);

        for (int n = 0; n < 12; n++) begin
            run_load($urandom, $urandom_range(1, 5), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        idle(3);
        check("final_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget, required completion");
        $fatal(1, "watchdog");
    end

endmodule
